// File: rtl/mib_cmd_slave.sv
// MIB responder: turns MIB address/data phases from the board master into
// single-cycle local command-bus transactions and returns write acks or read data.
module mib_cmd_slave #(
    parameter logic [3:0] P_MIB_MSN              = 4'h1,
    parameter int         P_CMD_ACK_TIMEOUT_CLKS = 16
) (
    input  logic        i_sysclk,
    input  logic        i_rst_n,
    input  logic        i_mib_start,
    input  logic        i_mib_rd_wr_n,
    input  logic [15:0] i_mib_ad,
    output logic [15:0] o_mib_ad,
    output logic        o_mib_ad_oe,
    output logic        o_mib_ack,
    output logic        o_cmd_sel,
    output logic        o_cmd_rd_wr_n,
    output logic [19:0] o_cmd_byte_addr,
    output logic [31:0] o_cmd_wdata,
    input  logic        i_cmd_ack,
    input  logic [31:0] i_cmd_rdata,
    output logic        o_cmd_timeout
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR2    = 3'd1;
    localparam logic [2:0] WR_HI    = 3'd2;
    localparam logic [2:0] WR_LO    = 3'd3;
    localparam logic [2:0] CMD_WAIT = 3'd4;
    localparam logic [2:0] RD_HI    = 3'd5;
    localparam logic [2:0] RD_LO    = 3'd6;
    localparam logic [2:0] WR_ACK   = 3'd7;

    localparam int               CNT_W    = $clog2(P_CMD_ACK_TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_CMD_ACK_TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [2:0]       state_q, state_d;
    logic             rd_wr_n_q, rd_wr_n_d;
    logic [23:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             ack_q, ack_d;
    logic             oe_q, oe_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      mib_ad_q, mib_ad_d;

    // A new start always wins: it aborts whatever is in flight, so a late
    // local ack simply lands outside CMD_WAIT and is ignored.
    always_comb begin
        state_d   = state_q;
        rd_wr_n_d = rd_wr_n_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        mib_ad_d  = mib_ad_q;
        sel_d     = 1'b0;
        ack_d     = 1'b0;
        oe_d      = 1'b0;
        timeout_d = 1'b0;

        if (i_mib_start) begin
            rd_wr_n_d     = i_mib_rd_wr_n;
            addr_d[23:16] = i_mib_ad[7:0];
            state_d       = ADDR2;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                ADDR2: begin
                    addr_d[15:0] = i_mib_ad;
                    if (addr_q[23:20] != P_MIB_MSN) begin
                        state_d = IDLE;
                    end else if (rd_wr_n_q) begin
                        state_d = CMD_WAIT;
                        sel_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = WR_HI;
                    end
                end
                WR_HI: begin
                    wdata_d[31:16] = i_mib_ad;
                    state_d        = WR_LO;
                end
                WR_LO: begin
                    wdata_d[15:0] = i_mib_ad;
                    state_d       = CMD_WAIT;
                    sel_d         = 1'b1;
                    cnt_d         = '0;
                end
                CMD_WAIT: begin
                    if (i_cmd_ack) begin
                        if (rd_wr_n_q) begin
                            rdata_d  = i_cmd_rdata;
                            mib_ad_d = i_cmd_rdata[31:16];
                            oe_d     = 1'b1;
                            ack_d    = 1'b1;
                            state_d  = RD_HI;
                        end else begin
                            ack_d   = 1'b1;
                            state_d = WR_ACK;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RD_HI: begin
                    mib_ad_d = rdata_q[15:0];
                    oe_d     = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = RD_LO;
                end
                RD_LO: begin
                    state_d = IDLE;
                end
                WR_ACK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            rd_wr_n_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            ack_q     <= 1'b0;
            oe_q      <= 1'b0;
            timeout_q <= 1'b0;
            mib_ad_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_wr_n_q <= rd_wr_n_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            ack_q     <= ack_d;
            oe_q      <= oe_d;
            timeout_q <= timeout_d;
            mib_ad_q  <= mib_ad_d;
        end
    end

    assign o_mib_ad        = mib_ad_q;
    assign o_mib_ad_oe     = oe_q;
    assign o_mib_ack       = ack_q;
    assign o_cmd_sel       = sel_q;
    assign o_cmd_rd_wr_n   = rd_wr_n_q;
    assign o_cmd_byte_addr = addr_q[19:0];
    assign o_cmd_wdata     = wdata_q;
    assign o_cmd_timeout   = timeout_q;

endmodule

// File: tb/tb_mib_cmd_slave.sv
// Directed bench for mib_cmd_slave: MIB writes/reads, MSN filtering, local
// ack timeout, restart on a new start, and reset in the middle of a read.
module tb_mib_cmd_slave;

    logic        clk;
    logic        rst_n;
    logic        mib_start;
    logic        mib_rd_wr_n;
    logic [15:0] mib_ad_in;
    logic [15:0] mib_ad_out;
    logic        mib_ad_oe;
    logic        mib_ack;
    logic        cmd_sel;
    logic        cmd_rd_wr_n;
    logic [19:0] cmd_byte_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_ack;
    logic [31:0] cmd_rdata;
    logic        cmd_timeout;

    int checks   = 0;
    int failures = 0;

    mib_cmd_slave #(
        .P_MIB_MSN             (4'h1),
        .P_CMD_ACK_TIMEOUT_CLKS(16)
    ) dut (
        .i_sysclk       (clk),
        .i_rst_n        (rst_n),
        .i_mib_start    (mib_start),
        .i_mib_rd_wr_n  (mib_rd_wr_n),
        .i_mib_ad       (mib_ad_in),
        .o_mib_ad       (mib_ad_out),
        .o_mib_ad_oe    (mib_ad_oe),
        .o_mib_ack      (mib_ack),
        .o_cmd_sel      (cmd_sel),
        .o_cmd_rd_wr_n  (cmd_rd_wr_n),
        .o_cmd_byte_addr(cmd_byte_addr),
        .o_cmd_wdata    (cmd_wdata),
        .i_cmd_ack      (cmd_ack),
        .i_cmd_rdata    (cmd_rdata),
        .o_cmd_timeout  (cmd_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_a1(input logic rd, input logic [7:0] a1);
        mib_start   = 1'b1;
        mib_rd_wr_n = rd;
        mib_ad_in   = {8'h00, a1};
        tick();
        mib_start   = 1'b0;
        mib_ad_in   = 16'h0000;
    endtask

    task automatic apply_word(input logic [15:0] w);
        mib_ad_in = w;
        tick();
        mib_ad_in = 16'h0000;
    endtask

    initial begin
        rst_n       = 1'b0;
        mib_start   = 1'b0;
        mib_rd_wr_n = 1'b0;
        mib_ad_in   = 16'h0000;
        cmd_ack     = 1'b0;
        cmd_rdata   = 32'h0;

        tick();
        tick();
        check_output("rst_oe",      mib_ad_oe,     32'h0);
        check_output("rst_ack",     mib_ack,       32'h0);
        check_output("rst_sel",     cmd_sel,       32'h0);
        check_output("rst_timeout", cmd_timeout,   32'h0);
        check_output("rst_ad",      mib_ad_out,    32'h0);
        check_output("rst_addr",    cmd_byte_addr, 32'h0);
        check_output("rst_wdata",   cmd_wdata,     32'h0);
        check_output("rst_rdwrn",   cmd_rd_wr_n,   32'h0);
        #3 rst_n = 1'b1;

        $display("[TB] write 0x100004 <= 0x01010202, local ack 2 clocks after sel");
        apply_a1(1'b0, 8'h10);
        apply_word(16'h0004);
        apply_word(16'h0101);
        apply_word(16'h0202);
        check_output("wr1_sel",   cmd_sel,       32'h1);
        check_output("wr1_addr",  cmd_byte_addr, 32'h00004);
        check_output("wr1_wdata", cmd_wdata,     32'h01010202);
        check_output("wr1_rdwrn", cmd_rd_wr_n,   32'h0);
        check_output("wr1_oe",    mib_ad_oe,     32'h0);
        tick();
        check_output("wr1_sel_one", cmd_sel,   32'h0);
        check_output("wr1_hold",    cmd_wdata, 32'h01010202);
        tick();
        check_output("wr1_noack_yet", mib_ack, 32'h0);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check_output("wr1_mib_ack", mib_ack, 32'h1);
        check_output("wr1_sel_off", cmd_sel, 32'h0);
        tick();
        check_output("wr1_ack_one", mib_ack,   32'h0);
        check_output("wr1_oe_end",  mib_ad_oe, 32'h0);

        $display("[TB] read 0x100000, local ack with sel, rdata 0xCAFE0001");
        apply_a1(1'b1, 8'h10);
        apply_word(16'h0000);
        check_output("rd1_sel",   cmd_sel,       32'h1);
        check_output("rd1_rdwrn", cmd_rd_wr_n,   32'h1);
        check_output("rd1_addr",  cmd_byte_addr, 32'h00000);
        check_output("rd1_oe0",   mib_ad_oe,     32'h0);
        cmd_ack   = 1'b1;
        cmd_rdata = 32'hCAFE0001;
        tick();
        cmd_ack   = 1'b0;
        cmd_rdata = 32'h0;
        check_output("rd1_hi_oe",  mib_ad_oe,  32'h1);
        check_output("rd1_hi_ack", mib_ack,    32'h1);
        check_output("rd1_hi_ad",  mib_ad_out, 32'hCAFE);
        tick();
        check_output("rd1_lo_oe",  mib_ad_oe,  32'h1);
        check_output("rd1_lo_ack", mib_ack,    32'h1);
        check_output("rd1_lo_ad",  mib_ad_out, 32'h0001);
        tick();
        check_output("rd1_end_oe",  mib_ad_oe,  32'h0);
        check_output("rd1_end_ack", mib_ack,    32'h0);
        check_output("rd1_ad_hold", mib_ad_out, 32'h0001);

        $display("[TB] MSN mismatch read at 0x20xxxx");
        apply_a1(1'b1, 8'h20);
        apply_word(16'h1234);
        check_output("msn_sel", cmd_sel,   32'h0);
        check_output("msn_oe",  mib_ad_oe, 32'h0);
        check_output("msn_ack", mib_ack,   32'h0);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check_output("msn_sel2", cmd_sel,   32'h0);
        check_output("msn_ack2", mib_ack,   32'h0);
        check_output("msn_oe2",  mib_ad_oe, 32'h0);

        $display("[TB] read with no local ack -> timeout");
        apply_a1(1'b1, 8'h10);
        apply_word(16'h0000);
        check_output("to_sel", cmd_sel, 32'h1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check_output("to_quiet", cmd_timeout, 32'h0);
        end
        tick();
        check_output("to_pulse",  cmd_timeout, 32'h1);
        check_output("to_no_ack", mib_ack,     32'h0);
        check_output("to_no_oe",  mib_ad_oe,   32'h0);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check_output("to_pulse_one", cmd_timeout, 32'h0);
        check_output("to_late_ack",  mib_ack,     32'h0);

        $display("[TB] write 0x110000 <= 0x64 after timeout");
        apply_a1(1'b0, 8'h11);
        apply_word(16'h0000);
        apply_word(16'h0000);
        apply_word(16'h0064);
        check_output("wr2_sel",   cmd_sel,       32'h1);
        check_output("wr2_addr",  cmd_byte_addr, 32'h10000);
        check_output("wr2_wdata", cmd_wdata,     32'h00000064);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check_output("wr2_mib_ack", mib_ack, 32'h1);
        tick();
        check_output("wr2_ack_one", mib_ack, 32'h0);

        $display("[TB] start reasserted during WR_HI");
        apply_a1(1'b0, 8'h10);
        apply_word(16'h0008);
        apply_a1(1'b1, 8'h10);
        check_output("ab_sel0", cmd_sel, 32'h0);
        apply_word(16'h0020);
        check_output("ab_sel",   cmd_sel,       32'h1);
        check_output("ab_rdwrn", cmd_rd_wr_n,   32'h1);
        check_output("ab_addr",  cmd_byte_addr, 32'h00020);
        cmd_ack   = 1'b1;
        cmd_rdata = 32'h12345678;
        tick();
        cmd_ack   = 1'b0;
        check_output("ab_hi_ad",  mib_ad_out, 32'h1234);
        check_output("ab_hi_ack", mib_ack,    32'h1);
        tick();
        check_output("ab_lo_ad", mib_ad_out, 32'h5678);
        tick();
        check_output("ab_end_oe", mib_ad_oe, 32'h0);

        $display("[TB] start reasserted during RD_HI");
        apply_a1(1'b1, 8'h10);
        apply_word(16'h0030);
        cmd_ack   = 1'b1;
        cmd_rdata = 32'hBEEF0102;
        tick();
        cmd_ack   = 1'b0;
        check_output("ab2_hi_oe", mib_ad_oe, 32'h1);
        apply_a1(1'b0, 8'h10);
        check_output("ab2_oe_drop",  mib_ad_oe, 32'h0);
        check_output("ab2_ack_drop", mib_ack,   32'h0);
        apply_word(16'h0040);
        apply_word(16'hDEAD);
        apply_word(16'hBEEF);
        check_output("ab2_sel",   cmd_sel,       32'h1);
        check_output("ab2_addr",  cmd_byte_addr, 32'h00040);
        check_output("ab2_wdata", cmd_wdata,     32'hDEADBEEF);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check_output("ab2_mib_ack", mib_ack, 32'h1);
        tick();

        $display("[TB] reset asserted during RD_HI");
        apply_a1(1'b1, 8'h10);
        apply_word(16'h0000);
        cmd_ack   = 1'b1;
        cmd_rdata = 32'hA5A55A5A;
        tick();
        cmd_ack   = 1'b0;
        check_output("rr_hi_oe", mib_ad_oe, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_output("rr_oe",  mib_ad_oe,  32'h0);
        check_output("rr_ack", mib_ack,    32'h0);
        check_output("rr_sel", cmd_sel,    32'h0);
        check_output("rr_ad",  mib_ad_out, 32'h0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        check_output("rr_idle_oe", mib_ad_oe, 32'h0);

        apply_a1(1'b0, 8'h10);
        apply_word(16'h0010);
        apply_word(16'h55AA);
        apply_word(16'h1234);
        check_output("bb_wr_sel",   cmd_sel,   32'h1);
        check_output("bb_wr_wdata", cmd_wdata, 32'h55AA1234);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check_output("bb_wr_ack", mib_ack, 32'h1);
        apply_a1(1'b1, 8'h10);
        apply_word(16'h0010);
        check_output("bb_rd_sel",  cmd_sel,       32'h1);
        check_output("bb_rd_addr", cmd_byte_addr, 32'h00010);
        cmd_ack   = 1'b1;
        cmd_rdata = 32'h55AA1234;
        tick();
        cmd_ack   = 1'b0;
        check_output("bb_rd_hi", mib_ad_out, 32'h55AA);
        tick();
        check_output("bb_rd_lo", mib_ad_out, 32'h1234);
        check_output("bb_rd_oe", mib_ad_oe,  32'h1);
        tick();
        check_output("bb_rd_end", mib_ad_oe, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
